// File: rtl/ram256_arbiter_if.sv
// rtl/ram256_arbiter_if.sv - client and RAM port-0 bundle for the two-client RAM arbiter
interface ram256_arbiter_if;
  logic        req0, req1;
  logic        wr0, wr1;
  logic [3:0]  be0, be1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        init_done;
  logic        ram_en0;
  logic [3:0]  ram_we;
  logic [7:0]  ram_a0;
  logic [31:0] ram_di;
  logic [31:0] ram_do0;

  modport master (
    output req0, req1, wr0, wr1, be0, be1, addr0, addr1, wdata0, wdata1, ram_do0,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done,
    input  ram_en0, ram_we, ram_a0, ram_di
  );

  modport slave (
    input  req0, req1, wr0, wr1, be0, be1, addr0, addr1, wdata0, wdata1, ram_do0,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done,
    output ram_en0, ram_we, ram_a0, ram_di
  );
endinterface

// File: rtl/ram256_arbiter.sv
// rtl/ram256_arbiter.sv - clears a 256-word RAM after reset, then round-robins two clients onto port 0
module ram256_arbiter (
  input logic             clk,
  input logic             rst,
  ram256_arbiter_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;

  state_t      state;
  logic [7:0]  clr_cnt;
  logic        last;      // 1 when client 1 held the most recent transfer
  logic        rv0_q, rv1_q;

  logic        run, g0, g1, xfer;
  logic        ram_en0, sel_wr;
  logic [3:0]  ram_we, sel_be;
  logic [7:0]  ram_a0, sel_addr;
  logic [31:0] ram_di, sel_wdata;

  assign run = (state == RUN) && !rst;
  assign g0  = run && bus.req0 && (!bus.req1 || last);
  assign g1  = run && bus.req1 && (!bus.req0 || !last);
  assign xfer = g0 || g1;

  assign sel_wr    = g1 ? bus.wr1    : bus.wr0;
  assign sel_be    = g1 ? bus.be1    : bus.be0;
  assign sel_addr  = g1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = g1 ? bus.wdata1 : bus.wdata0;

  always_comb begin
    ram_en0 = 1'b0;
    ram_we  = 4'h0;
    ram_a0  = 8'h00;
    ram_di  = 32'h0;
    if (!rst && state == INIT) begin
      ram_en0 = 1'b1;
      ram_we  = 4'hF;
      ram_a0  = clr_cnt;
    end else if (xfer) begin
      ram_en0 = 1'b1;
      ram_we  = sel_wr ? sel_be : 4'h0;
      ram_a0  = sel_addr;
      ram_di  = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= 8'h00;
      last    <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 8'h01;
          rv0_q   <= 1'b0;
          rv1_q   <= 1'b0;
          if (clr_cnt == 8'hFF) state <= RUN;
        end
        RUN: begin
          rv0_q <= g0 && !bus.wr0;
          rv1_q <= g1 && !bus.wr1;
          if (xfer) last <= g1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Read data is the RAM's registered output, only passed through alongside its RVALID
  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.init_done = run;
  assign bus.rvalid0   = rv0_q && !rst;
  assign bus.rvalid1   = rv1_q && !rst;
  assign bus.rdata0    = bus.rvalid0 ? bus.ram_do0 : 32'h0;
  assign bus.rdata1    = bus.rvalid1 ? bus.ram_do0 : 32'h0;
  assign bus.ram_en0   = ram_en0;
  assign bus.ram_we    = ram_we;
  assign bus.ram_a0    = ram_a0;
  assign bus.ram_di    = ram_di;
endmodule

// File: doc/ram256_arbiter.md
RAM256_ARBITER -- requirements
Module: ram256_arbiter

Interface
REQ-001 The block SHALL use one clock, CLK; reset is RST, synchronous and active-high; no other clock or reset SHALL exist.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 REQ0 / REQ1  in  1  client c requests one RAM access this cycle.
REQ-005 WR0 / WR1  in  1  client c access type: 1 = write, 0 = read.
REQ-006 BE0 / BE1  in  4  client c byte enables; bit n covers data bits [8n+7:8n]; used only when WRc=1.
REQ-007 ADDR0 / ADDR1  in  8  client c word address.
REQ-008 WDATA0 / WDATA1  in  32  client c write data.
REQ-009 GNT0 / GNT1  out  1  grant to client c; an access transfers when REQc and GNTc are both 1.
REQ-010 RVALID0 / RVALID1  out  1  read data for client c is valid this cycle.
REQ-011 RDATA0 / RDATA1  out  32  read data for client c.
REQ-012 INIT_DONE  out  1  memory clear has finished; the arbiter is accepting requests.
REQ-013 RAM_EN0  out  1  drives RAM port-0 enable.
REQ-014 RAM_WE  out  4  drives RAM port-0 byte write enables.
REQ-015 RAM_A0  out  8  drives RAM port-0 address.
REQ-016 RAM_DI  out  32  drives RAM write data.
REQ-017 RAM_DO0  in  32  RAM port-0 read data, registered inside the RAM with 1-cycle latency; the RAM returns 0 on any cycle following EN0=0.

Function
REQ-018 The block SHALL have two states: INIT and RUN.
REQ-019 INIT behaviour: an 8-bit clear counter starts at 0. Every cycle the block drives RAM_EN0=1, RAM_WE=4'hF, RAM_A0=counter and RAM_DI=0, then increments the counter.
REQ-020 INIT exit: after the cycle that writes address 255, the state SHALL change to RUN, so INIT lasts exactly 256 cycles. INIT_DONE SHALL be 1 exactly when the state is RUN.
REQ-021 In INIT, GNT0, GNT1, RVALID0 and RVALID1 SHALL be 0, and REQ inputs SHALL be ignored.
REQ-022 Grant logic in RUN: GNTc SHALL be combinational from the REQ inputs and a priority pointer, and at most one GNT SHALL be 1 per cycle.
REQ-023 Single request: if only one client requests, that client SHALL be granted.
REQ-024 Both requesting: the client not granted most recently SHALL be granted. The pointer resets so that client 0 wins the first tie.
REQ-025 The pointer SHALL update only on a transfer.
REQ-026 On a transfer, the block SHALL drive RAM_EN0=1, RAM_A0=ADDRc and RAM_DI=WDATAc.
REQ-027 On a transfer, RAM_WE SHALL equal BEc when WRc=1 and 4'h0 when WRc=0.
REQ-028 A write with BEc=0 SHALL still consume the grant and SHALL leave memory unchanged.
REQ-029 On a RUN cycle with no transfer, the block SHALL drive RAM_EN0=0, RAM_WE=0, RAM_A0=0 and RAM_DI=0.
REQ-030 Read response: a read transfer from client c in cycle N SHALL produce RVALIDc=1 in cycle N+1, with RDATAc=RAM_DO0 in that cycle.
REQ-031 When RVALIDc=0, RDATAc SHALL be 0. Writes SHALL produce no RVALID.
REQ-032 Back-to-back reads, from the same client or alternating clients, SHALL sustain one transfer per cycle, with each response in order, one cycle after its request.
REQ-033 A write followed by a read of the same address in the next cycle SHALL return the newly written bytes. Unwritten bytes SHALL keep their prior values.
REQ-034 REQc may deassert without a grant; no request SHALL be latched across cycles.

Reset
REQ-035 A cycle with RST=1 SHALL set the state to INIT, set the clear counter to 0, reset the pointer so client 0 is preferred, and clear both RVALID registers at the next edge.
REQ-036 While RST=1, every output SHALL be 0.
REQ-037 RST asserted during RUN SHALL discard any pending read response (no RVALID after reset) and SHALL restart the full 256-cycle clear.
REQ-038 RST asserted during INIT SHALL restart the clear from address 0.

Verification
REQ-039 Reset and clear: release RST, then hold REQ0=REQ1=1. Required: no GNT for 256 cycles, RAM_A0 steps 0..255 with RAM_WE=F and RAM_DI=0, and INIT_DONE=1 on cycle 257. A subsequent read of address 0x80 returns 0.
REQ-040 Write then read: client 0 writes 0xDEADBEEF to address 0x10 with BE=F, then reads 0x10 in the next cycle. Required: RVALID0=1 one cycle after the read with RDATA0=0xDEADBEEF, and RVALID1 stays 0.
REQ-041 Byte enable: with address 0x10 holding 0xDEADBEEF, client 1 writes 0x11223344 with BE=4'b0101, then reads 0x10. Required: RDATA1=0xDE22BE44.
REQ-042 Fairness: both clients request reads continuously for 6 cycles after INIT. Required: grants are 0,1,0,1,0,1 and each RVALID follows its grant by exactly one cycle.
REQ-043 Reset mid-read: client 0 reads in cycle N and RST=1 in cycle N+1. Required: RVALID0=0, all outputs are 0 during reset, and a full 256-cycle clear follows the reset.
